// File: rtl/gpio_debounce_irq_if.sv
// Pad-side and control/status signals of the GPIO input conditioner, grouped per channel vector.
// master drives raw pads and control masks; slave is the conditioner itself.
interface gpio_debounce_irq_if #(
   parameter int CH = 17
);
   logic [CH-1:0] raw_i;
   logic [CH-1:0] rise_en_i;
   logic [CH-1:0] fall_en_i;
   logic [CH-1:0] irq_en_i;
   logic [CH-1:0] clr_i;
   logic [CH-1:0] level_o;
   logic [CH-1:0] rise_o;
   logic [CH-1:0] fall_o;
   logic [CH-1:0] pending_o;
   logic          irq_o;

   modport master (
      output raw_i, rise_en_i, fall_en_i, irq_en_i, clr_i,
      input  level_o, rise_o, fall_o, pending_o, irq_o
   );

   modport slave (
      input  raw_i, rise_en_i, fall_en_i, irq_en_i, clr_i,
      output level_o, rise_o, fall_o, pending_o, irq_o
   );
endinterface

// File: rtl/gpio_debounce_irq.sv
// Per-channel synchronizer, counter debouncer, edge detect, sticky pending and masked IRQ.
// Level/edge latency SYNC_STAGES+DEBOUNCE_CYCLES clocks, irq one clock later; no backpressure.
module gpio_debounce_irq #(
   parameter int CH              = 17,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic               clk_i,
   input  logic               rst_i,
   gpio_debounce_irq_if.slave bus
);
   localparam int CW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0][CH-1:0] sync_q, sync_d;
   logic [CH-1:0][CW-1:0]          cnt_q, cnt_d;
   logic [CH-1:0]                  level_q, level_d;
   logic [CH-1:0]                  rise_q, rise_d;
   logic [CH-1:0]                  fall_q, fall_d;
   logic [CH-1:0]                  pending_q, pending_d;
   logic                           irq_q, irq_d;
   logic [CH-1:0]                  s;

   always_comb begin
      sync_d    = sync_q;
      sync_d[0] = bus.raw_i;
      for (int k = 1; k < SYNC_STAGES; k++) begin
         sync_d[k] = sync_q[k-1];
      end
      s = sync_q[SYNC_STAGES-1];
   end

   // Counter only runs while the synchronized input disagrees with the accepted level;
   // any return to agreement restarts the count, which is what rejects short glitches.
   always_comb begin
      cnt_d   = cnt_q;
      level_d = level_q;
      rise_d  = '0;
      fall_d  = '0;
      for (int i = 0; i < CH; i++) begin
         if (s[i] == level_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_LAST) begin
            cnt_d[i]   = '0;
            level_d[i] = s[i];
            rise_d[i]  = s[i];
            fall_d[i]  = ~s[i];
         end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
         end
      end
   end

   // Set terms are OR'd after the clear so a coincident event keeps the flag up.
   always_comb begin
      pending_d = (pending_q & ~bus.clr_i)
                | (bus.rise_en_i & rise_d)
                | (bus.fall_en_i & fall_d);
      irq_d     = |(pending_q & bus.irq_en_i);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q    <= '0;
         cnt_q     <= '0;
         level_q   <= '0;
         rise_q    <= '0;
         fall_q    <= '0;
         pending_q <= '0;
         irq_q     <= 1'b0;
      end else begin
         sync_q    <= sync_d;
         cnt_q     <= cnt_d;
         level_q   <= level_d;
         rise_q    <= rise_d;
         fall_q    <= fall_d;
         pending_q <= pending_d;
         irq_q     <= irq_d;
      end
   end

   assign bus.level_o   = level_q;
   assign bus.rise_o    = rise_q;
   assign bus.fall_o    = fall_q;
   assign bus.pending_o = pending_q;
   assign bus.irq_o     = irq_q;
endmodule
